// File: rtl/ram_loader.sv
// Streams a length/data/checksum image into RAM and holds the CPU in reset until it verifies.
// Latency: each RAM write appears one cycle after its byte is accepted; one byte per cycle.
// Backpressure: in_ready depends only on state; in_valid gaps stall the load.
module ram_loader #(
    parameter int                   MEM_WIDTH = 8,
    parameter int                   WORD_SIZE = 8,
    parameter logic [WORD_SIZE-1:0] BASE_ADDR = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [MEM_WIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WORD_SIZE-1:0] ld_addr,
    output logic [MEM_WIDTH-1:0] ld_data,
    output logic                 ld_wr_en,
    output logic                 bus_own,
    output logic                 cpu_rst,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [2:0] {IDLE, HDR, DATA, CHK, DONE, ERR} state_t;

    state_t               state_q, state_d;
    logic [MEM_WIDTH-1:0] cnt_q, cnt_d;
    logic [MEM_WIDTH-1:0] acc_q, acc_d;
    logic [MEM_WIDTH-1:0] data_q, data_d;
    logic [WORD_SIZE-1:0] ptr_q, ptr_d;
    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic                 wr_q, wr_d;
    logic                 xfer;

    assign xfer = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            ptr_q   <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        wr_d    = 1'b0;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) state_d = HDR;
            end
            HDR: begin
                if (xfer) begin
                    cnt_d   = in_data;
                    acc_d   = '0;
                    ptr_d   = BASE_ADDR;
                    state_d = (in_data == '0) ? CHK : DATA;
                end
            end
            DATA: begin
                if (xfer) begin
                    addr_d = ptr_q;
                    data_d = in_data;
                    wr_d   = 1'b1;
                    acc_d  = acc_q ^ in_data;
                    ptr_d  = ptr_q + WORD_SIZE'(1);
                    cnt_d  = cnt_q - MEM_WIDTH'(1);
                    // cnt_q still holds the count before this byte
                    if (cnt_q == MEM_WIDTH'(1)) state_d = CHK;
                end
            end
            CHK: begin
                if (xfer) state_d = (in_data == acc_q) ? DONE : ERR;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake and status are pure state decodes, so none of them sees in_valid combinationally
    assign in_ready = (state_q == HDR) || (state_q == DATA) || (state_q == CHK);
    assign bus_own  = in_ready;
    assign cpu_rst  = (state_q != DONE);
    assign done     = (state_q == DONE);
    assign err      = (state_q == ERR);
    assign ld_addr  = addr_q;
    assign ld_data  = data_q;
    assign ld_wr_en = wr_q;

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench: two loaders (base 0x00 and base 0xFE) share the byte stream; RAM modelled from the write port.
module tb_ram_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, start_b;
    logic       in_valid;
    logic [7:0] in_data;

    logic       in_ready_a, ld_wr_en_a, bus_own_a, cpu_rst_a, done_a, err_a;
    logic [7:0] ld_addr_a, ld_data_a;
    logic       in_ready_b, ld_wr_en_b, bus_own_b, cpu_rst_b, done_b, err_b;
    logic [7:0] ld_addr_b, ld_data_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] mem_a [256];
    logic [7:0] wa_q[$], wd_q[$], wb_addr_q[$], wb_data_q[$];
    int         wc_q[$];

    ram_loader #(.MEM_WIDTH(8), .WORD_SIZE(8), .BASE_ADDR(8'h00)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_a), .ld_addr(ld_addr_a), .ld_data(ld_data_a), .ld_wr_en(ld_wr_en_a),
        .bus_own(bus_own_a), .cpu_rst(cpu_rst_a), .done(done_a), .err(err_a)
    );

    ram_loader #(.MEM_WIDTH(8), .WORD_SIZE(8), .BASE_ADDR(8'hFE)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_b), .ld_addr(ld_addr_b), .ld_data(ld_data_b), .ld_wr_en(ld_wr_en_b),
        .bus_own(bus_own_b), .cpu_rst(cpu_rst_b), .done(done_b), .err(err_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // A one-cycle write strobe is seen at exactly one falling edge
    always @(negedge clk) begin
        if (ld_wr_en_a) begin
            mem_a[ld_addr_a] = ld_data_a;
            wa_q.push_back(ld_addr_a);
            wd_q.push_back(ld_data_a);
            wc_q.push_back(cyc);
        end
        if (ld_wr_en_b) begin
            wb_addr_q.push_back(ld_addr_b);
            wb_data_q.push_back(ld_data_b);
        end
    end

    task automatic clear_log();
        wa_q.delete(); wd_q.delete(); wc_q.delete();
        wb_addr_q.delete(); wb_data_q.delete();
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Presents a byte and returns at the falling edge after the accepting rising edge
    task automatic send(input logic [7:0] b, input bit sel);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!(sel ? in_ready_b : in_ready_a) && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 20) begin
            errors++;
            $display("FAIL send_timeout byte %h: in_ready stayed 0, required 1", b);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; start_a = 1'b0; start_b = 1'b0; in_valid = 1'b1; in_data = 8'h55;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready_a, ld_wr_en_a, bus_own_a, cpu_rst_a, done_a, err_a} !== 6'b000100) begin
            errors++;
            $display("FAIL reset_ctl got %b required 000100",
                     {in_ready_a, ld_wr_en_a, bus_own_a, cpu_rst_a, done_a, err_a});
        end
        checks++;
        if ({ld_addr_a, ld_data_a} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_addr_data got %h required 0000", {ld_addr_a, ld_data_a});
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready_a !== 1'b0 || wa_q.size() != 0) begin
            errors++;
            $display("FAIL idle_no_accept in_ready %b writes %0d required 0 0", in_ready_a, wa_q.size());
        end
        in_valid = 1'b0;
    endtask

    task automatic test_basic();
        clear_log();
        pulse_start(1'b0);
        send(8'h03, 1'b0); send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0);
        checks++;
        if ({ld_wr_en_a, bus_own_a, ld_addr_a, ld_data_a} !== {2'b11, 8'h02, 8'h33}) begin
            errors++;
            $display("FAIL basic_last_write got %b %b %h %h required 1 1 02 33",
                     ld_wr_en_a, bus_own_a, ld_addr_a, ld_data_a);
        end
        send(8'h00, 1'b0);
        in_valid = 1'b0;
        checks++;
        if ({done_a, err_a, cpu_rst_a, bus_own_a, in_ready_a, ld_wr_en_a} !== 6'b100000) begin
            errors++;
            $display("FAIL basic_done got %b required 100000",
                     {done_a, err_a, cpu_rst_a, bus_own_a, in_ready_a, ld_wr_en_a});
        end
        #2;
        checks++;
        if (wa_q.size() != 3) begin
            errors++;
            $display("FAIL basic_write_count got %0d required 3", wa_q.size());
        end else begin
            checks++;
            if ({wa_q[0], wd_q[0], wa_q[1], wd_q[1], wa_q[2], wd_q[2]} !== 48'h00_11_01_22_02_33) begin
                errors++;
                $display("FAIL basic_writes got %h %h %h %h %h %h required 00 11 01 22 02 33",
                         wa_q[0], wd_q[0], wa_q[1], wd_q[1], wa_q[2], wd_q[2]);
            end
            checks++;
            if (wc_q[1] != wc_q[0] + 1 || wc_q[2] != wc_q[1] + 1) begin
                errors++;
                $display("FAIL basic_consecutive cycles %0d %0d %0d required consecutive",
                         wc_q[0], wc_q[1], wc_q[2]);
            end
        end
        checks++;
        if ({mem_a[0], mem_a[1], mem_a[2]} !== 24'h112233) begin
            errors++;
            $display("FAIL basic_readback got %h %h %h required 11 22 33", mem_a[0], mem_a[1], mem_a[2]);
        end
    endtask

    task automatic test_bad_checksum();
        clear_log();
        pulse_start(1'b0);
        send(8'h02, 1'b0); send(8'hA5, 1'b0); send(8'h5A, 1'b0); send(8'h00, 1'b0);
        in_valid = 1'b0;
        checks++;
        if ({done_a, err_a, cpu_rst_a, bus_own_a} !== 4'b0110) begin
            errors++;
            $display("FAIL bad_err got %b required 0110", {done_a, err_a, cpu_rst_a, bus_own_a});
        end
        #2;
        checks++;
        if (wa_q.size() != 2 || mem_a[0] !== 8'hA5 || mem_a[1] !== 8'h5A) begin
            errors++;
            $display("FAIL bad_writes got count %0d data %h %h required 2 a5 5a", wa_q.size(), mem_a[0], mem_a[1]);
        end
        pulse_start(1'b0);
        checks++;
        if ({err_a, done_a, in_ready_a, cpu_rst_a} !== 4'b0011) begin
            errors++;
            $display("FAIL bad_restart got %b required 0011", {err_a, done_a, in_ready_a, cpu_rst_a});
        end
        send(8'h00, 1'b0); send(8'h00, 1'b0);
        in_valid = 1'b0;
        checks++;
        if ({done_a, err_a} !== 2'b10) begin
            errors++;
            $display("FAIL bad_recover got %b required 10", {done_a, err_a});
        end
    endtask

    task automatic test_empty();
        clear_log();
        pulse_start(1'b0);
        send(8'h00, 1'b0); send(8'h00, 1'b0);
        in_valid = 1'b0;
        #2;
        checks++;
        if ({done_a, err_a, cpu_rst_a} !== 3'b100 || wa_q.size() != 0) begin
            errors++;
            $display("FAIL empty_good got %b writes %0d required 100 0", {done_a, err_a, cpu_rst_a}, wa_q.size());
        end
        pulse_start(1'b0);
        send(8'h00, 1'b0); send(8'h01, 1'b0);
        in_valid = 1'b0;
        checks++;
        if ({done_a, err_a, cpu_rst_a} !== 3'b011) begin
            errors++;
            $display("FAIL empty_bad got %b required 011", {done_a, err_a, cpu_rst_a});
        end
    endtask

    task automatic test_wrap_stall();
        logic [7:0] bytes [4];
        bytes[0] = 8'h10; bytes[1] = 8'h20; bytes[2] = 8'h40; bytes[3] = 8'h70;
        clear_log();
        pulse_start(1'b1);
        send(8'h03, 1'b1);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (in_ready_b !== 1'b1 || ld_wr_en_b !== 1'b0) begin
                errors++;
                $display("FAIL wrap_gap%0d in_ready %b wr_en %b required 1 0", i, in_ready_b, ld_wr_en_b);
            end
            send(bytes[i], 1'b1);
        end
        in_valid = 1'b0;
        #2;
        checks++;
        if (done_b !== 1'b1 || wb_addr_q.size() != 3) begin
            errors++;
            $display("FAIL wrap_done done %b writes %0d required 1 3", done_b, wb_addr_q.size());
        end else begin
            checks++;
            if ({wb_addr_q[0], wb_addr_q[1], wb_addr_q[2]} !== 24'hFEFF00 ||
                {wb_data_q[0], wb_data_q[1], wb_data_q[2]} !== 24'h102040) begin
                errors++;
                $display("FAIL wrap_addrs got %h %h %h / %h %h %h required fe ff 00 / 10 20 40",
                         wb_addr_q[0], wb_addr_q[1], wb_addr_q[2], wb_data_q[0], wb_data_q[1], wb_data_q[2]);
            end
        end
    endtask

    task automatic test_abort_reload();
        clear_log();
        pulse_start(1'b0);
        send(8'h04, 1'b0); send(8'hAA, 1'b0); send(8'hBB, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({ld_wr_en_a, in_ready_a, bus_own_a, cpu_rst_a, done_a} !== 5'b00010) begin
            errors++;
            $display("FAIL abort_state got %b required 00010",
                     {ld_wr_en_a, in_ready_a, bus_own_a, cpu_rst_a, done_a});
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (wa_q.size() != 2 || mem_a[0] !== 8'hAA || mem_a[1] !== 8'hBB || in_ready_a !== 1'b0) begin
            errors++;
            $display("FAIL abort_partial got count %0d data %h %h ready %b required 2 aa bb 0",
                     wa_q.size(), mem_a[0], mem_a[1], in_ready_a);
        end
        clear_log();
        pulse_start(1'b0);
        send(8'h02, 1'b0); send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0);
        in_valid = 1'b0;
        #2;
        checks++;
        if ({done_a, err_a, cpu_rst_a} !== 3'b100 || mem_a[0] !== 8'h01 || mem_a[1] !== 8'h02) begin
            errors++;
            $display("FAIL reload got %b data %h %h required 100 01 02",
                     {done_a, err_a, cpu_rst_a}, mem_a[0], mem_a[1]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_checksum();
        test_empty();
        test_wrap_stall();
        test_abort_reload();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
